mem_wb_stage: RTL and testbench

Memory-access stage plus MEM/WB pipeline register for the pd5 pipeline. It takes the executed instruction and issues the data-memory request with byte enables. It registers the control and data bundle consumed by the writeback stage, and sign- or zero-extends load data returned by the synchronous data memory. It also holds load data across stalls so the writeback stage always sees a stable bundle.

---
 rtl/mem_wb_stage_pkg.sv | 40 ++++
 rtl/mem_wb_stage_load_align.sv | 35 +++
 rtl/mem_wb_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the pd5 MEM/WB stage.
// Funct3 load/store codes, wbsel codes, load-hold states, WB bundle.
package mem_wb_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_JAL = 2'd3;

  typedef enum logic {
    LIVE,
    HELD
  } hold_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_res;
    logic [1:0]      wbsel;
    logic            brtaken;
    logic            regwren;
    logic [4:0]      rd;
    logic            memread;
    logic [2:0]      funct3;
    logic [1:0]      off;
    logic            misalign;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load lane extraction and sign/zero extension.
// Purely combinational; offset is already naturally aligned.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DWIDTH-1:0] data
);

  logic [DWIDTH-1:0] sh_b;
  logic [DWIDTH-1:0] sh_h;
  logic [7:0]        b;
  logic [15:0]       h;

  assign sh_b = word >> {off, 3'b000};
  assign sh_h = word >> {off[1], 4'b0000};
  assign b    = sh_b[7:0];
  assign h    = sh_h[15:0];

  always_comb begin
    data = word;
    unique case (1'b1)
      funct3 == F3_LB:  data = {{(DWIDTH-8){b[7]}}, b};
      funct3 == F3_LBU: data = {{(DWIDTH-8){1'b0}}, b};
      funct3 == F3_LH:  data = {{(DWIDTH-16){h[15]}}, h};
      funct3 == F3_LHU: data = {{(DWIDTH-16){1'b0}}, h};
      default:          data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// pd5 memory-access stage and MEM/WB register with load-data hold.
// Optional misalignment trap: define MISALIGN_CHECK_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  input  logic [AWIDTH-1:0] ex_pc_i,
  input  logic [DWIDTH-1:0] ex_alu_res_i,
  input  logic [DWIDTH-1:0] ex_rs2_data_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic              ex_memread_i,
  input  logic              ex_memwrite_i,
  input  logic [1:0]        ex_wbsel_i,
  input  logic              ex_regwren_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              ex_brtaken_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_be_o,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [AWIDTH-1:0] wb_pc_o,
  output logic [DWIDTH-1:0] wb_alu_res_o,
  output logic [1:0]        wb_wbsel_o,
  output logic              wb_brtaken_o,
  output logic              wb_regwren_o,
  output logic [4:0]        wb_rd_o,
  output logic [DWIDTH-1:0] wb_memory_data_o,
  output logic              wb_misalign_o
);

  logic        mem_op;
  logic        misalign;
  logic [1:0]  a;
  logic [1:0]  sz;
  logic [1:0]  off;
  mem_wb_t     wb_q;
  mem_wb_t     wb_d;
  logic        is_load;
  logic [DWIDTH-1:0] aligned;
  logic [DWIDTH-1:0] hold_q;
  logic        hold_en;
  hold_state_e state_q;
  hold_state_e state_d;

  assign mem_op = ex_memread_i | ex_memwrite_i;
  assign a      = ex_alu_res_i[1:0];
  assign sz     = ex_funct3_i[1:0];

`ifdef MISALIGN_CHECK_EN
  assign misalign = mem_op &
    (((sz == 2'b01) & a[0]) | (sz[1] & (a != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    off = a;
    unique case (1'b1)
      sz == 2'b00: off = a;
      sz == 2'b01: off = {a[1], 1'b0};
      default:     off = 2'b00;
    endcase
  end

  // Gated by reset so no store can escape while the core is held in reset.
  assign dmem_req_o = reset & ex_valid_i & mem_op &
                      ~stall_i & ~flush_i & ~misalign;
  assign dmem_we_o  = dmem_req_o & ex_memwrite_i;
  assign dmem_addr_o = ex_valid_i ?
    {ex_alu_res_i[AWIDTH-1:2], 2'b00} : '0;

  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = '0;
    if (ex_valid_i) begin
      unique case (1'b1)
        sz == 2'b00: begin
          dmem_be_o    = 4'b0001 << a;
          dmem_wdata_o = {4{ex_rs2_data_i[7:0]}};
        end
        sz == 2'b01: begin
          dmem_be_o    = 4'b0011 << {a[1], 1'b0};
          dmem_wdata_o = {2{ex_rs2_data_i[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'b1111;
          dmem_wdata_o = ex_rs2_data_i;
        end
      endcase
    end
  end

  always_comb begin
    wb_d          = '0;
    wb_d.valid    = ex_valid_i;
    wb_d.pc       = ex_pc_i;
    wb_d.alu_res  = ex_alu_res_i;
    wb_d.wbsel    = ex_wbsel_i;
    wb_d.brtaken  = ex_brtaken_i;
    wb_d.regwren  = ex_regwren_i & ~misalign;
    wb_d.rd       = ex_rd_i;
    wb_d.memread  = ex_memread_i;
    wb_d.funct3   = ex_funct3_i;
    wb_d.off      = off;
    wb_d.misalign = ex_valid_i & misalign;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q <= '0;
    end else if (flush_i) begin
      wb_q <= '0;
    end else if (!stall_i) begin
      wb_q <= wb_d;
    end
  end

  assign is_load = wb_q.valid & wb_q.memread & ~wb_q.misalign;

  mem_wb_stage_load_align #(
    .DWIDTH(DWIDTH)
  ) u_load_align (
    .word  (dmem_rdata_i),
    .off   (wb_q.off),
    .funct3(wb_q.funct3),
    .data  (aligned)
  );

  always_comb begin
    state_d = state_q;
    hold_en = 1'b0;
    unique case (state_q)
      LIVE: begin
        if (stall_i & ~flush_i & is_load) begin
          state_d = HELD;
          hold_en = 1'b1;
        end
      end
      HELD: begin
        if (flush_i | ~stall_i) state_d = LIVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LIVE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hold_en) hold_q <= aligned;
    end
  end

  assign wb_memory_data_o = !is_load ? '0 :
    (state_q == HELD) ? hold_q : aligned;

  assign wb_valid_o    = wb_q.valid;
  assign wb_pc_o       = wb_q.pc;
  assign wb_alu_res_o  = wb_q.alu_res;
  assign wb_wbsel_o    = wb_q.wbsel;
  assign wb_brtaken_o  = wb_q.brtaken;
  assign wb_regwren_o  = wb_q.regwren;
  assign wb_rd_o       = wb_q.rd;
  assign wb_misalign_o = wb_q.misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus random
// traffic against a behavioural model of the stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_alu_res_i;
  logic [31:0] ex_rs2_data_i;
  logic [2:0]  ex_funct3_i;
  logic        ex_memread_i;
  logic        ex_memwrite_i;
  logic [1:0]  ex_wbsel_i;
  logic        ex_regwren_i;
  logic [4:0]  ex_rd_i;
  logic        ex_brtaken_i;
  logic        stall_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_alu_res_o;
  logic [1:0]  wb_wbsel_o;
  logic        wb_brtaken_o;
  logic        wb_regwren_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_memory_data_o;
  logic        wb_misalign_o;

  mem_wb_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid_i      (ex_valid_i),
    .ex_pc_i         (ex_pc_i),
    .ex_alu_res_i    (ex_alu_res_i),
    .ex_rs2_data_i   (ex_rs2_data_i),
    .ex_funct3_i     (ex_funct3_i),
    .ex_memread_i    (ex_memread_i),
    .ex_memwrite_i   (ex_memwrite_i),
    .ex_wbsel_i      (ex_wbsel_i),
    .ex_regwren_i    (ex_regwren_i),
    .ex_rd_i         (ex_rd_i),
    .ex_brtaken_i    (ex_brtaken_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_rdata_i    (dmem_rdata_i),
    .wb_valid_o      (wb_valid_o),
    .wb_pc_o         (wb_pc_o),
    .wb_alu_res_o    (wb_alu_res_o),
    .wb_wbsel_o      (wb_wbsel_o),
    .wb_brtaken_o    (wb_brtaken_o),
    .wb_regwren_o    (wb_regwren_o),
    .wb_rd_o         (wb_rd_o),
    .wb_memory_data_o(wb_memory_data_o),
    .wb_misalign_o   (wb_misalign_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model of the WB register contents
  logic        m_valid, m_br, m_wren, m_rd_en, m_misal;
  logic [31:0] m_pc, m_alu;
  logic [1:0]  m_wbsel, m_off;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  bit          fresh;
  logic [31:0] latched;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] extract(logic [31:0] w,
                                          logic [2:0] f3,
                                          logic [1:0] off);
    int n;
    logic [31:0] v, mask;
    n = 1 << f3[1:0];
    v = w >> (8 * off);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // naturally aligned offset and misalignment of current EX access
  function automatic logic [1:0] nat_off();
    int n;
    n = 1 << ex_funct3_i[1:0];
    return ex_alu_res_i[1:0] & 2'(~(n - 1));
  endfunction

  function automatic logic cur_misal();
`ifdef MISALIGN_CHECK_EN
    int n;
    n = 1 << ex_funct3_i[1:0];
    return (ex_memread_i || ex_memwrite_i) &&
           ((ex_alu_res_i % n) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare();
    int n;
    logic mem, e_req;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_md;
    n = 1 << ex_funct3_i[1:0];
    mem = ex_memread_i || ex_memwrite_i;
    e_req = reset && ex_valid_i && mem && !stall_i && !flush_i &&
            !cur_misal();
    e_be = ex_valid_i ? 4'(((1 << n) - 1) << nat_off()) : 4'd0;
    if (!ex_valid_i) e_wd = 0;
    else if (n == 1) e_wd = ex_rs2_data_i[7:0] * 32'h01010101;
    else if (n == 2) e_wd = ex_rs2_data_i[15:0] * 32'h00010001;
    else e_wd = ex_rs2_data_i;
    check("req", dmem_req_o, e_req);
    check("we", dmem_we_o, e_req && ex_memwrite_i);
    check("addr", dmem_addr_o,
          ex_valid_i ? (ex_alu_res_i & 32'hFFFFFFFC) : 0);
    check("be", dmem_be_o, e_be);
    check("wdata", dmem_wdata_o, e_wd);
    check("wb_valid", wb_valid_o, m_valid);
    check("wb_pc", wb_pc_o, m_pc);
    check("wb_alu", wb_alu_res_o, m_alu);
    check("wb_wbsel", wb_wbsel_o, m_wbsel);
    check("wb_br", wb_brtaken_o, m_br);
    check("wb_wren", wb_regwren_o, m_wren);
    check("wb_rd", wb_rd_o, m_rd);
    check("wb_misal", wb_misalign_o, m_misal);
    if (m_valid && m_rd_en && !m_misal) begin
      if (fresh) begin
        e_md = extract(dmem_rdata_i, m_f3, m_off);
        latched = e_md;
      end else begin
        e_md = latched;
      end
    end else begin
      e_md = 0;
    end
    check("wb_mdata", wb_memory_data_o, e_md);
  endtask

  task automatic update();
    if (!reset || flush_i) begin
      {m_valid, m_br, m_wren, m_rd_en, m_misal} = '0;
      {m_pc, m_alu, m_wbsel, m_off, m_rd, m_f3} = '0;
      fresh = 1;
    end else if (stall_i) begin
      fresh = 0;
    end else begin
      m_valid = ex_valid_i;
      m_pc    = ex_pc_i;
      m_alu   = ex_alu_res_i;
      m_wbsel = ex_wbsel_i;
      m_br    = ex_brtaken_i;
      m_wren  = ex_regwren_i && !cur_misal();
      m_rd    = ex_rd_i;
      m_rd_en = ex_memread_i;
      m_f3    = ex_funct3_i;
      m_off   = nat_off();
      m_misal = ex_valid_i && cur_misal();
      fresh   = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic idle();
    ex_valid_i = 0; ex_pc_i = 0; ex_alu_res_i = 0; ex_rs2_data_i = 0;
    ex_funct3_i = 0; ex_memread_i = 0; ex_memwrite_i = 0;
    ex_wbsel_i = 0; ex_regwren_i = 0; ex_rd_i = 0; ex_brtaken_i = 0;
    stall_i = 0; flush_i = 0;
  endtask

  task automatic rnd_inputs();
    logic [2:0] ld_f3 [5];
    int k;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    ex_valid_i    = ($urandom_range(0, 9) < 8);
    ex_pc_i       = $urandom;
    ex_alu_res_i  = $urandom;
    ex_rs2_data_i = $urandom;
    ex_wbsel_i    = 2'($urandom);
    ex_regwren_i  = 1'($urandom);
    ex_rd_i       = 5'($urandom);
    ex_brtaken_i  = 1'($urandom);
    k = $urandom_range(0, 2);
    ex_memread_i  = (k == 1);
    ex_memwrite_i = (k == 2);
    if (k == 1) ex_funct3_i = ld_f3[$urandom_range(0, 4)];
    else ex_funct3_i = 3'($urandom_range(0, 2));
    stall_i      = ($urandom_range(0, 3) == 0);
    flush_i      = ($urandom_range(0, 9) == 0);
    dmem_rdata_i = $urandom;
  endtask

  task automatic load_at(logic [31:0] addr, logic [2:0] f3);
    idle();
    ex_valid_i = 1; ex_pc_i = 32'h400; ex_alu_res_i = addr;
    ex_funct3_i = f3; ex_memread_i = 1; ex_regwren_i = 1;
    ex_wbsel_i = 2'd1; ex_rd_i = 5'd7;
  endtask

  initial begin
    {m_valid, m_br, m_wren, m_rd_en, m_misal} = '0;
    {m_pc, m_alu, m_wbsel, m_off, m_rd, m_f3} = '0;
    fresh = 1; latched = 0;
    reset = 0;
    rnd_inputs();
    @(posedge clk); #1;
    rnd_inputs(); cycle();
    rnd_inputs(); cycle();
    check("rst_valid", wb_valid_o, 0);
    check("rst_pc", wb_pc_o, 0);
    check("rst_misal", wb_misalign_o, 0);
    check("rst_mdata", wb_memory_data_o, 0);
    check("rst_req", dmem_req_o, 0);
    reset = 1;
    idle(); dmem_rdata_i = 0;
    cycle();

    // SB 0xA5 to 0x103
    idle();
    ex_valid_i = 1; ex_alu_res_i = 32'h103; ex_rs2_data_i = 32'hA5;
    ex_funct3_i = 3'b000; ex_memwrite_i = 1;
    #1;
    check("sb_be", dmem_be_o, 4'b1000);
    check("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
    check("sb_addr", dmem_addr_o, 32'h100);
    check("sb_we", dmem_we_o, 1);
    cycle();

    // LB / LBU from 0x102
    load_at(32'h102, 3'b000); cycle();
    idle(); dmem_rdata_i = 32'h0080FF00; #1;
    check("lb_data", wb_memory_data_o, 32'hFFFFFF80);
    cycle();
    load_at(32'h102, 3'b100); cycle();
    idle(); dmem_rdata_i = 32'h0080FF00; #1;
    check("lbu_data", wb_memory_data_o, 32'h00000080);
    cycle();

    // LW held across a 3-cycle stall
    load_at(32'h100, 3'b010); cycle();
    idle(); stall_i = 1; dmem_rdata_i = 32'h12345678; #1;
    check("lw_data", wb_memory_data_o, 32'h12345678);
    cycle();
    for (int i = 0; i < 2; i++) begin
      stall_i = 1; dmem_rdata_i = 32'hDEADBEEF; #1;
      check("lw_hold", wb_memory_data_o, 32'h12345678);
      cycle();
    end
    stall_i = 0; #1;
    check("lw_hold_end", wb_memory_data_o, 32'h12345678);
    check("lw_pc_hold", wb_pc_o, 32'h400);
    cycle();

    // stall and flush together with SW in EX
    idle();
    ex_valid_i = 1; ex_alu_res_i = 32'h200; ex_funct3_i = 3'b010;
    ex_memwrite_i = 1; ex_regwren_i = 1; stall_i = 1; flush_i = 1;
    #1;
    check("sf_req", dmem_req_o, 0);
    cycle();
    check("sf_valid", wb_valid_o, 0);
    check("sf_wren", wb_regwren_o, 0);

    // LW at 0x102
    load_at(32'h102, 3'b010); #1;
`ifdef MISALIGN_CHECK_EN
    check("mis_req", dmem_req_o, 0);
    cycle();
    check("mis_flag", wb_misalign_o, 1);
    check("mis_wren", wb_regwren_o, 0);
`else
    check("mis_addr", dmem_addr_o, 32'h100);
    check("mis_be", dmem_be_o, 4'b1111);
    cycle();
    check("mis_flag", wb_misalign_o, 0);
`endif

    // random traffic, occasional reset
    for (int i = 0; i < 600; i++) begin
      rnd_inputs();
      reset = ($urandom_range(0, 49) != 0);
      cycle();
    end
    reset = 1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
